// File: rtl/pipe_collision_scorer.sv
// Collision detector and score keeper for one pipe against the bird.
// Geometry is evaluated in 12-bit signed arithmetic so edge offsets never wrap.
//
// state | meaning
// IDLE  | waiting for Start; inputs ignored, Score/HighScore held
// PLAY  | collision and pass checks active every cycle
// LOST  | Lost asserted, Score frozen; Start returns to IDLE
module pipe_collision_scorer #(
  parameter int BIRD_X     = 200,
  parameter int BIRD_R     = 10,
  parameter int PIPE_W     = 60,
  parameter int GAP_H      = 60,
  parameter int FLOOR_Y    = 515,
  parameter int HIT_CYCLES = 2,
  parameter int SCORE_MAX  = 999
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] PipePosX,
  input  logic [9:0] PipePosY,
  input  logic [9:0] BirdPosY,
  output logic       Lost,
  output logic [9:0] Score,
  output logic [9:0] HighScore,
  output logic       ScoreTick
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_LOST = 2'd2
  } state_t;

  localparam logic signed [11:0] BIRD_RIGHT = 12'(BIRD_X + BIRD_R);
  localparam logic signed [11:0] BIRD_LEFT  = 12'(BIRD_X - BIRD_R);
  localparam logic signed [11:0] PIPE_SPAN  = 12'(PIPE_W - 1);
  localparam logic signed [11:0] GAP_HALF   = 12'(GAP_H);
  localparam logic signed [11:0] RADIUS     = 12'(BIRD_R);
  localparam logic signed [11:0] FLOOR_ROW  = 12'(FLOOR_Y);
  localparam logic [3:0]         HIT_LIMIT  = 4'(HIT_CYCLES);
  localparam logic [9:0]         SCORE_TOP  = 10'(SCORE_MAX);

  state_t     state, state_nxt;
  logic [3:0] hit_cnt, hit_nxt;
  logic       passed_q, passed_nxt;
  logic [9:0] score_nxt, high_nxt;
  logic       tick_nxt;

  logic signed [11:0] px, py, by;
  logic signed [11:0] pipe_right, gap_top, gap_bot, bird_top, bird_bot;
  logic               xov, yhit, bound, hit, passed_now, pass_evt;

  assign px = signed'({2'b00, PipePosX});
  assign py = signed'({2'b00, PipePosY});
  assign by = signed'({2'b00, BirdPosY});

  assign pipe_right = px + PIPE_SPAN;
  assign gap_top    = py - GAP_HALF;
  assign gap_bot    = py + GAP_HALF;
  assign bird_top   = by - RADIUS;
  assign bird_bot   = by + RADIUS;

  assign xov        = (px <= BIRD_RIGHT) && (pipe_right >= BIRD_LEFT);
  // Touching a gap edge exactly is still inside the gap.
  assign yhit       = (bird_top < gap_top) || (bird_bot > gap_bot);
  assign bound      = (bird_bot >= FLOOR_ROW) || (by < RADIUS);
  assign hit        = (xov && yhit) || bound;
  assign passed_now = (pipe_right < BIRD_LEFT);
  assign pass_evt   = passed_now && !passed_q;

  always_comb begin
    state_nxt  = state;
    hit_nxt    = hit_cnt;
    passed_nxt = passed_q;
    score_nxt  = Score;
    high_nxt   = HighScore;
    tick_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nxt  = S_PLAY;
          score_nxt  = '0;
          hit_nxt    = '0;
          // Pretend the pipe was already passed so a pipe left of the bird
          // at game start does not score.
          passed_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        passed_nxt = passed_now;
        if (pass_evt && (Score != SCORE_TOP)) begin
          score_nxt = Score + 10'd1;
          tick_nxt  = 1'b1;
        end
        if (hit) begin
          hit_nxt = (hit_cnt >= HIT_LIMIT) ? HIT_LIMIT : hit_cnt + 4'd1;
        end else begin
          hit_nxt = '0;
        end
        // A pass landing on the losing cycle still counts toward HighScore.
        if (hit && (hit_nxt == HIT_LIMIT)) begin
          state_nxt = S_LOST;
          if (score_nxt > HighScore) begin
            high_nxt = score_nxt;
          end
        end
      end
      S_LOST: begin
        if (Start) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      hit_cnt   <= '0;
      passed_q  <= 1'b0;
      Lost      <= 1'b0;
      Score     <= '0;
      HighScore <= '0;
      ScoreTick <= 1'b0;
    end else begin
      state     <= state_nxt;
      hit_cnt   <= hit_nxt;
      passed_q  <= passed_nxt;
      Lost      <= (state_nxt == S_LOST);
      Score     <= score_nxt;
      HighScore <= high_nxt;
      ScoreTick <= tick_nxt;
    end
  end

endmodule
